fwd_hazard_ctrl: RTL

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

---
 rtl/fwd_hazard_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Forwarding and hazard control for a 5-stage in-order pipeline.
//   Tracks shadow copies of the EX, MEM and WB destination info and decides,
//   for the instruction in ID, whether to stall (load-use or long EX op) and
//   which bypass path each of its source operands uses once it reaches EX.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   id_valid       instruction present in ID
//   id_rs          NUM_SRC packed 5-bit source register addresses
//   id_rs_used     per-source read enable
//   id_rd          destination register of the ID instruction
//   id_reg_write   ID instruction writes id_rd
//   id_is_load     ID instruction is a load
//   id_is_long     ID instruction is a long (mul/div) op
//   flush          kill the ID instruction and the EX entry
//   stall          hold PC and IF/ID this cycle
//   ex_fwd_sel     registered per-source select: 00 RF, 01 EX/MEM, 10 MEM/WB
//   ex_bubble      EX holds no valid instruction
//   stall_count    saturating count of stalled cycles
//   dbg_state      FSM state (0 = IDLE, 1 = LONG)
//   dbg_wb         WB shadow entry {valid, rd, wr, load}
module fwd_hazard_ctrl #(
    parameter int NUM_SRC  = 2,
    parameter int LONG_LAT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [5*NUM_SRC-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]     id_rs_used,
    input  logic [4:0]             id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_is_load,
    input  logic                   id_is_long,
    input  logic                   flush,
    output logic                   stall,
    output logic [2*NUM_SRC-1:0]   ex_fwd_sel,
    output logic                   ex_bubble,
    output logic [CNT_W-1:0]       stall_count,
    output logic                   dbg_state,
    output logic [7:0]             dbg_wb
);

    typedef enum logic {
        IDLE = 1'b0,
        LONG = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       load;
    } stage_t;

    stage_t                 ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    state_t                 state_q, state_d;
    logic [3:0]             busy_cnt_q, busy_cnt_d;
    logic [2*NUM_SRC-1:0]   fwd_q, fwd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   load_use;
    logic [2*NUM_SRC-1:0]   fwd_new;

    // Source matching against the EX and MEM shadows. WB is not a bypass
    // source because the register file writes through to the read port.
    always_comb begin
        logic [4:0] rs;
        logic       base;
        logic       m_ex;
        logic       m_mem;
        load_use = 1'b0;
        fwd_new  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs    = id_rs[5*i +: 5];
            base  = id_valid & id_rs_used[i];
            m_ex  = base & ex_q.valid & ex_q.wr & (ex_q.rd != 5'd0) & (ex_q.rd == rs);
            m_mem = base & mem_q.valid & mem_q.wr & (mem_q.rd != 5'd0) & (mem_q.rd == rs);
            if (m_ex && ex_q.load) begin
                load_use = 1'b1;
            end
            if (m_ex) begin
                fwd_new[2*i +: 2] = 2'b01;
            end else if (m_mem) begin
                fwd_new[2*i +: 2] = 2'b10;
            end
        end
    end

    assign stall = ~flush & ((state_q == LONG) | (load_use & (state_q == IDLE)));

    always_comb begin
        ex_d       = ex_q;
        mem_d      = ex_q;
        wb_d       = mem_q;
        fwd_d      = fwd_q;
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        cnt_d      = cnt_q;

        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (flush) begin
            ex_d       = '0;
            fwd_d      = '0;
            state_d    = IDLE;
            busy_cnt_d = 4'd0;
        end else if (state_q == LONG) begin
            // Long op stays in EX; selects hold because the EX unit only
            // latched its operands in the first EX cycle.
            mem_d      = '0;
            busy_cnt_d = busy_cnt_q - 4'd1;
            if (busy_cnt_q == 4'd1) begin
                state_d = IDLE;
            end
        end else if (load_use) begin
            ex_d  = '0;
            fwd_d = '0;
        end else begin
            ex_d.valid = id_valid;
            ex_d.rd    = id_rd;
            ex_d.wr    = id_reg_write;
            ex_d.load  = id_is_load;
            fwd_d      = fwd_new;
            if (id_valid && id_is_long) begin
                state_d    = LONG;
                busy_cnt_d = 4'(LONG_LAT - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            fwd_q      <= '0;
            state_q    <= IDLE;
            busy_cnt_q <= 4'd0;
            cnt_q      <= '0;
        end else begin
            ex_q       <= ex_d;
            mem_q      <= mem_d;
            wb_q       <= wb_d;
            fwd_q      <= fwd_d;
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_fwd_sel  = fwd_q;
    assign ex_bubble   = ~ex_q.valid;
    assign stall_count = cnt_q;
    assign dbg_state   = state_q;
    assign dbg_wb      = wb_q;

endmodule
